// File: rtl/mps_mc_sequencer.sv
// mps_mc_sequencer: main-contactor power-up/power-down sequencer with precharge, settle, discharge and fault latch.
// Optional contactor feedback supervision is built only when MC_FB_CHECK_EN is defined.
module mps_mc_sequencer #(
    parameter int T_PRE_MAX = 200000000,
    parameter int T_SETTLE  = 10000000,
    parameter int T_DIS     = 40000000,
    parameter int FB_DEB    = 2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_on_req,
    input  logic        i_off_req,
    input  logic        i_intl,
    input  logic        i_fault_clr,
    input  logic [31:0] i_dc_v,
    input  logic [31:0] i_dc_v_th,
    input  logic [1:0]  i_mc_fb,
    output logic [2:0]  o_mc,
    output logic        o_ready,
    output logic        o_fault,
    output logic [2:0]  o_fault_code,
    output logic [3:0]  o_state
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        PRECHG  = 4'd1,
        MAIN_ON = 4'd2,
        SETTLE  = 4'd3,
        READY   = 4'd4,
        OFF     = 4'd5,
        DISCHG  = 4'd6,
        FAULT   = 4'd7
    } state_t;

    localparam int M1   = T_PRE_MAX > T_SETTLE ? T_PRE_MAX : T_SETTLE;
    localparam int MAXP = M1 > T_DIS ? M1 : T_DIS;
    localparam int CW   = MAXP > 1 ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] PRE_END = CW'(T_PRE_MAX - 1);
    localparam logic [CW-1:0] SET_END = CW'(T_SETTLE - 1);
    localparam logic [CW-1:0] DIS_END = CW'(T_DIS - 1);

    state_t        r_state;
    state_t        w_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_mc;
    logic          r_ready;
    logic          r_fault;
    logic [2:0]    r_code;
    logic [2:0]    w_code;
    logic          w_act;
    logic          w_deb_hit;

    function automatic logic [2:0] mc_of(input state_t s);
        return (s == PRECHG) ? 3'b001 :
               (s == MAIN_ON) ? 3'b011 :
               (s == SETTLE || s == READY) ? 3'b010 :
               (s == DISCHG || s == FAULT) ? 3'b100 : 3'b000;
    endfunction

`ifdef MC_FB_CHECK_EN
    localparam int DW = FB_DEB > 1 ? $clog2(FB_DEB) : 1;
    logic [DW-1:0] r_deb;
    logic          w_mis;
    // Feedback is compared against the registered drive, which is steady in SETTLE/READY.
    assign w_mis     = (r_state == SETTLE || r_state == READY) && (i_mc_fb != r_mc[1:0]);
    assign w_deb_hit = w_mis && (r_deb == DW'(FB_DEB - 1));
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_deb <= '0;
        else        r_deb <= (w_mis && !w_deb_hit) ? r_deb + 1'b1 : '0;
    end
`else
    logic w_unused;
    assign w_unused  = ^i_mc_fb;
    assign w_deb_hit = 1'b0;
`endif

    assign w_act = (r_state == PRECHG) || (r_state == MAIN_ON) || (r_state == SETTLE) || (r_state == READY);

    always_comb begin
        w_nxt  = r_state;
        w_code = r_code;
        if (r_state == FAULT) begin
            if (i_fault_clr && !i_intl) begin
                w_nxt  = IDLE;
                w_code = 3'd0;
            end
        end else if (i_intl) begin
            w_nxt  = FAULT;
            w_code = 3'd1;
        end else if (w_deb_hit) begin
            w_nxt  = FAULT;
            w_code = 3'd3;
        end else if (w_act && (i_off_req || !i_on_req)) begin
            w_nxt = OFF;
        end else begin
            case (r_state)
                IDLE:    if (i_on_req && !i_off_req) w_nxt = PRECHG;
                PRECHG:  if (i_dc_v >= i_dc_v_th) w_nxt = MAIN_ON;
                         else if (r_cnt == PRE_END) begin
                             w_nxt  = FAULT;
                             w_code = 3'd2;
                         end
                MAIN_ON: if (r_cnt == SET_END) w_nxt = SETTLE;
                SETTLE:  if (r_cnt == SET_END) w_nxt = READY;
                OFF:     if (r_cnt == SET_END) w_nxt = DISCHG;
                DISCHG:  if (r_cnt == DIS_END) w_nxt = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mc    <= 3'b000;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= 3'd0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (w_nxt != r_state) ? '0 : (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            r_mc    <= mc_of(w_nxt);
            r_ready <= (w_nxt == READY);
            r_fault <= (w_nxt == FAULT);
            r_code  <= w_code;
        end
    end

    assign o_mc         = r_mc;
    assign o_ready      = r_ready;
    assign o_fault      = r_fault;
    assign o_fault_code = r_code;
    assign o_state      = r_state;
endmodule

// File: tb/tb_mps_mc_sequencer.sv
// tb_mps_mc_sequencer: directed stimulus with a per-cycle state/dwell model of the contactor sequencer.
module tb_mps_mc_sequencer;
    localparam int TP = 100;
    localparam int TS = 10;
    localparam int TD = 20;
    localparam int FD = 5;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        on_req = 0;
    logic        off_req = 0;
    logic        intl = 0;
    logic        clr = 0;
    logic [31:0] dc_v = 0;
    logic [31:0] dc_th = 1000;
    logic [1:0]  fb = 2'b10;
    logic [2:0]  mc;
    logic        rdy;
    logic        flt;
    logic [2:0]  code;
    logic [3:0]  st;

    int n_cmp = 0;
    int n_bad = 0;
    int n;
    int m_st = 0;
    int m_dw = 0;
    int m_code = 0;
    int m_mis = 0;
    int ns;
    bit mf;
    int mc_tab[8] = '{0, 1, 3, 2, 2, 0, 4, 4};

    mps_mc_sequencer #(.T_PRE_MAX(TP), .T_SETTLE(TS), .T_DIS(TD), .FB_DEB(FD)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_on_req(on_req), .i_off_req(off_req),
        .i_intl(intl), .i_fault_clr(clr), .i_dc_v(dc_v), .i_dc_v_th(dc_th),
        .i_mc_fb(fb), .o_mc(mc), .o_ready(rdy), .o_fault(flt),
        .o_fault_code(code), .o_state(st)
    );

    always #5 clk = ~clk;

    // Model: m_dw is how many edges the state has already been held, so a state of length T leaves when m_dw+1 == T.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_dw = 0; m_code = 0; m_mis = 0;
        end else begin
            ns = m_st;
            mf = 0;
`ifdef MC_FB_CHECK_EN
            if (m_st == 3 || m_st == 4) begin
                m_mis = (fb != 2'b10) ? m_mis + 1 : 0;
                mf = (m_mis >= FD);
            end else m_mis = 0;
`endif
            if (m_st == 7) begin
                if (clr && !intl) begin ns = 0; m_code = 0; end
            end
            else if (intl) begin ns = 7; m_code = 1; end
            else if (mf) begin ns = 7; m_code = 3; end
            else if (m_st >= 1 && m_st <= 4 && (off_req || !on_req)) ns = 5;
            else if (m_st == 0 && on_req && !off_req) ns = 1;
            else if (m_st == 1 && dc_v >= dc_th) ns = 2;
            else if (m_st == 1 && m_dw + 1 == TP) begin ns = 7; m_code = 2; end
            else if ((m_st == 2 || m_st == 3 || m_st == 5) && m_dw + 1 == TS) ns = (m_st == 2) ? 3 : (m_st == 3) ? 4 : 6;
            else if (m_st == 6 && m_dw + 1 == TD) ns = 0;
            m_dw = (ns != m_st) ? 0 : m_dw + 1;
            m_st = ns;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n_cmp++;
        if (st !== 4'(m_st) || mc !== 3'(mc_tab[m_st]) || rdy !== (m_st == 4) || flt !== (m_st == 7) || code !== 3'(m_code)) begin
            n_bad++;
            $display("FAIL model t=%0t state/mc/rdy/flt/code got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                     $time, st, mc, rdy, flt, code, m_st, mc_tab[m_st], m_st == 4, m_st == 7, m_code);
        end
    endtask

    task automatic dwell(input int s, output int cnt);
        cnt = 0;
        while (st == 4'(s) && cnt < 500) begin
            cnt++;
            step();
        end
    endtask

    task automatic wait_st(input int s);
        int k;
        k = 0;
        while (st != 4'(s) && k < 300) begin
            k++;
            step();
        end
        chk("reach state", int'(st), s);
    endtask

    initial begin
        #1 rst_n = 0;
        step();
        step();
        chk("reset state", int'(st), 0);
        chk("reset mc", int'(mc), 0);
        chk("reset code", int'(code), 0);
        rst_n = 1;
        step();
        on_req = 1;
        step();
        chk("prechg state", int'(st), 1);
        chk("prechg mc", int'(mc), 1);
        for (int k = 1; k < 30; k++) begin
            dc_v = 32'(k * 30);
            step();
        end
        dc_v = 1000;
        step();
        chk("main_on mc", int'(mc), 3);
        dwell(2, n);
        chk("main_on dwell", n, 10);
        chk("settle mc", int'(mc), 2);
        dwell(3, n);
        chk("settle dwell", n, 10);
        chk("ready state", int'(st), 4);
        chk("ready flag", int'(rdy), 1);
        intl = 1;
        step();
        chk("intl state", int'(st), 7);
        chk("intl code", int'(code), 1);
        chk("intl mc", int'(mc), 4);
        chk("intl fault", int'(flt), 1);
        clr = 1;
        step();
        clr = 0;
        chk("clr under intl", int'(st), 7);
        intl = 0;
        on_req = 0;
        step();
        clr = 1;
        step();
        clr = 0;
        chk("clr to idle", int'(st), 0);
        chk("clr code", int'(code), 0);
        dc_v = 500;
        on_req = 1;
        step();
        chk("prechg again", int'(st), 1);
        dwell(1, n);
        chk("prechg timeout dwell", n, 100);
        chk("timeout state", int'(st), 7);
        chk("timeout code", int'(code), 2);
        chk("timeout mc", int'(mc), 4);
        on_req = 0;
        clr = 1;
        step();
        clr = 0;
        chk("timeout clr", int'(st), 0);
        chk("timeout clr code", int'(code), 0);
        dc_v = 1000;
        on_req = 1;
        wait_st(4);
        off_req = 1;
        step();
        chk("off state", int'(st), 5);
        chk("off mc", int'(mc), 0);
        off_req = 0;
        dwell(5, n);
        chk("off dwell", n, 10);
        chk("dischg mc", int'(mc), 4);
        dwell(6, n);
        chk("dischg dwell", n, 20);
        chk("dischg to idle", int'(st), 0);
        on_req = 0;
        step();
        dc_v = 500;
        on_req = 1;
        step();
        chk("tie prechg", int'(st), 1);
        for (int k = 0; k < 99; k++) step();
        dc_v = 1000;
        step();
        chk("threshold beats timeout", int'(st), 2);
        on_req = 0;
        wait_st(0);
        on_req = 1;
        wait_st(4);
        fb = 2'b00;
`ifdef MC_FB_CHECK_EN
        repeat (4) step();
        fb = 2'b10;
        repeat (3) step();
        chk("fb 4 cycles", int'(st), 4);
        fb = 2'b00;
        repeat (5) step();
        chk("fb mismatch state", int'(st), 7);
        chk("fb mismatch code", int'(code), 3);
        fb = 2'b10;
        on_req = 0;
        clr = 1;
        step();
        clr = 0;
        chk("fb clr", int'(st), 0);
`else
        repeat (10) step();
        chk("fb ignored state", int'(st), 4);
        chk("fb ignored code", int'(code), 0);
        fb = 2'b10;
        on_req = 0;
        wait_st(0);
`endif
        on_req = 1;
        wait_st(2);
        #2 rst_n = 0;
        #1;
        chk("async reset mc", int'(mc), 0);
        chk("async reset state", int'(st), 0);
        step();
        on_req = 0;
        rst_n = 1;
        step();
        chk("after reset idle", int'(st), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
